// File: rtl/inv_aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryptor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package inv_aes_pkg;

  localparam int NR       = 10;
  localparam int NK_WORDS = 4;
  localparam int BLOCK_W  = 128;
  localparam int CNT_W    = 4;
  localparam int KS_DEPTH = NR + 1;

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, HOLD} state_e;

  typedef logic [CNT_W-1:0]   rnd_cnt_t;
  typedef logic [3:0]         key_idx_t;   // 0..10 used
  typedef logic [BLOCK_W-1:0] block_t;

  localparam key_idx_t KEY_IDX_LAST = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] g;
    g = ginv(x);
    return g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'h1:    v = 8'h01;
      4'h2:    v = 8'h02;
      4'h3:    v = 8'h04;
      4'h4:    v = 8'h08;
      4'h5:    v = 8'h10;
      4'h6:    v = 8'h20;
      4'h7:    v = 8'h40;
      4'h8:    v = 8'h80;
      4'h9:    v = 8'h1b;
      4'ha:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/inv_add_round_keys.sv
// Round-key addition (block XOR key).
// Latency: combinational.
// Backpressure: none.
// Ports: state_in, round_key -> state_out.
module inv_add_round_keys
  import inv_aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] round_key,
  output logic [BLOCK_W-1:0] state_out
);

  assign state_out = state_in ^ round_key;

endmodule

// File: rtl/inv_aes_key_store.sv
// 11-entry round-key register file with schedule-complete flag.
// Latency: 1-cycle write, combinational read.
// Backpressure: none; a write is taken every cycle wr_en is high.
// Ports: wr_en/wr_idx/wr_key write port, rd_idx/rd_key read port, key_valid flag.
module inv_aes_key_store
  import inv_aes_pkg::*;
#(
  parameter logic [BLOCK_W-1:0] RST_KEY = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [3:0]         wr_idx,
  input  logic [BLOCK_W-1:0] wr_key,
  input  logic [3:0]         rd_idx,
  output logic [BLOCK_W-1:0] rd_key,
  output logic               key_valid
);

  logic [BLOCK_W-1:0] mem [KS_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KS_DEPTH; i++) mem[i] <= (i == 0) ? RST_KEY : '0;
      key_valid <= 1'b0;
    end else if (wr_en && (wr_idx <= KEY_IDX_LAST)) begin
      mem[wr_idx] <= wr_key;
      // A new entry 0 starts a fresh schedule; entry 10 completes it.
      if (wr_idx == 4'd0)              key_valid <= 1'b0;
      else if (wr_idx == KEY_IDX_LAST) key_valid <= 1'b1;
    end
  end

  assign rd_key = (rd_idx <= KEY_IDX_LAST) ? mem[rd_idx] : '0;

endmodule

// File: rtl/inv_keygen.sv
// One AES-128 key-expansion step: round key i from round key i-1.
// Latency: combinational.
// Backpressure: none.
// Ports: rcon_idx (1..10), key_in (round key i-1) -> key_out (round key i).
module inv_keygen
  import inv_aes_pkg::*;
(
  input  logic [3:0]         rcon_idx,
  input  logic [BLOCK_W-1:0] key_in,
  output logic [BLOCK_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    {w0, w1, w2, w3} = key_in;
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon(rcon_idx), 24'h000000};
    n0 = w0 ^ sub;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    key_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/inv_round.sv
// One inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Latency: combinational.
// Backpressure: none.
// Ports: state_in, last (skips InvMixColumns), round_key -> state_out.
module inv_round
  import inv_aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic               last,
  input  logic [BLOCK_W-1:0] round_key,
  output logic [BLOCK_W-1:0] state_out
);

  // Byte k sits at bits [127-8k -: 8]; byte index = row + 4*col.
  logic [7:0] in_b [16];
  logic [7:0] ak_b [16];
  logic [7:0] mc_b [16];

  always_comb begin
    state_out = '0;
    for (int k = 0; k < 16; k++) in_b[k] = state_in[127 - 8*k -: 8];

    // Row r rotates right by r columns, then substitutes and adds the key.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ak_b[r + 4*c] = inv_sbox(in_b[r + 4*((c - r + 4) % 4)])
                        ^ round_key[127 - 8*(r + 4*c) -: 8];
      end
    end

    for (int c = 0; c < 4; c++) begin
      mc_b[4*c+0] = gmul(ak_b[4*c], 8'h0e) ^ gmul(ak_b[4*c+1], 8'h0b)
                  ^ gmul(ak_b[4*c+2], 8'h0d) ^ gmul(ak_b[4*c+3], 8'h09);
      mc_b[4*c+1] = gmul(ak_b[4*c], 8'h09) ^ gmul(ak_b[4*c+1], 8'h0e)
                  ^ gmul(ak_b[4*c+2], 8'h0b) ^ gmul(ak_b[4*c+3], 8'h0d);
      mc_b[4*c+2] = gmul(ak_b[4*c], 8'h0d) ^ gmul(ak_b[4*c+1], 8'h09)
                  ^ gmul(ak_b[4*c+2], 8'h0e) ^ gmul(ak_b[4*c+3], 8'h0b);
      mc_b[4*c+3] = gmul(ak_b[4*c], 8'h0b) ^ gmul(ak_b[4*c+1], 8'h0d)
                  ^ gmul(ak_b[4*c+2], 8'h09) ^ gmul(ak_b[4*c+3], 8'h0e);
    end

    for (int k = 0; k < 16; k++) state_out[127 - 8*k -: 8] = last ? ak_b[k] : mc_b[k];
  end

endmodule

// File: rtl/inv_aes_iter_ctrl.sv
// Iterative AES-128 decryption controller sharing one round, one keygen and one key adder.
// Latency: 21 cycles accept->out_valid with key load, 11 with key reuse.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
// Ports: clk, rst_n; in_valid/in_ready/in_key_load/key/cipher_text request side;
//        out_valid/out_ready/plain_text result side; busy, key_valid, err_nokey status.
module inv_aes_iter_ctrl
  import inv_aes_pkg::*;
#(
  parameter int                 NR      = 10,
  parameter logic [BLOCK_W-1:0] RST_KEY = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_key_load,
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-1:0] cipher_text,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] plain_text,
  output logic               busy,
  output logic               key_valid,
  output logic               err_nokey
);

  if (NR != inv_aes_pkg::NR) begin : g_nr_bad
    $error("inv_aes_iter_ctrl supports only NR = 10");
  end

  state_e             state_q, state_d;
  rnd_cnt_t           cnt_q, cnt_d;    // rcon index in EXPAND, round number in DECRYPT
  logic [BLOCK_W-1:0] blk_q, blk_d;

  logic               ks_wr_en;
  key_idx_t           ks_wr_idx, ks_rd_idx;
  logic [BLOCK_W-1:0] ks_wr_key, ks_rd_key;
  logic [BLOCK_W-1:0] keygen_out, ark_out, round_out;
  logic               in_hs;

  inv_aes_key_store #(.RST_KEY(RST_KEY)) u_key_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (ks_wr_en),
    .wr_idx    (ks_wr_idx),
    .wr_key    (ks_wr_key),
    .rd_idx    (ks_rd_idx),
    .rd_key    (ks_rd_key),
    .key_valid (key_valid)
  );

  inv_keygen u_keygen (
    .rcon_idx (cnt_q),
    .key_in   (ks_rd_key),
    .key_out  (keygen_out)
  );

  inv_add_round_keys u_ark (
    .state_in  (blk_q),
    .round_key (ks_rd_key),
    .state_out (ark_out)
  );

  inv_round u_round (
    .state_in  (blk_q),
    .last      (cnt_q == 4'd10),
    .round_key (ks_rd_key),
    .state_out (round_out)
  );

  // The single read port serves the keygen (previous entry) during EXPAND
  // and the reversed schedule (entry 10-r) during DECRYPT.
  always_comb begin
    ks_rd_idx = 4'd0;
    case (state_q)
      EXPAND:  ks_rd_idx = cnt_q - 4'd1;
      DECRYPT: ks_rd_idx = KEY_IDX_LAST - cnt_q;
      default: ks_rd_idx = 4'd0;
    endcase
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign in_hs     = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == EXPAND) || (state_q == DECRYPT);
  assign err_nokey = in_hs && !in_key_load && !key_valid;
  assign plain_text = blk_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    ks_wr_en  = 1'b0;
    ks_wr_idx = cnt_q;
    ks_wr_key = keygen_out;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          blk_d = cipher_text;
          if (in_key_load) begin
            ks_wr_en  = 1'b1;
            ks_wr_idx = 4'd0;
            ks_wr_key = key;
            cnt_d     = 4'd1;
            state_d   = EXPAND;
          end else if (key_valid) begin
            cnt_d   = 4'd0;
            state_d = DECRYPT;
          end
        end
      end
      EXPAND: begin
        ks_wr_en = 1'b1;
        if (cnt_q == 4'd10) begin
          cnt_d   = 4'd0;
          state_d = DECRYPT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DECRYPT: begin
        blk_d = (cnt_q == 4'd0) ? ark_out : round_out;
        if (cnt_q == 4'd10) begin
          cnt_d   = 4'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

endmodule

// File: tb/tb_inv_aes_iter_ctrl.sv
module tb_inv_aes_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_key_load;
  logic [127:0] key, cipher_text, plain_text;
  logic         out_valid, out_ready, busy, key_valid, err_nokey;

  int total = 0;
  int bad   = 0;
  logic [127:0] sb [$];

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  inv_aes_iter_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_key_load (in_key_load),
    .key         (key),
    .cipher_text (cipher_text),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .plain_text  (plain_text),
    .busy        (busy),
    .key_valid   (key_valid),
    .err_nokey   (err_nokey)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_req(input logic kl, input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] pt);
    in_valid = 1'b1; in_key_load = kl; key = k; cipher_text = ct;
    sb.push_back(pt);
    #1;
    for (int i = 0; i < 60 && !in_ready; i++) begin
      @(negedge clk); #1;
    end
    chk("accept_rdy", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_key_load = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_check(input string tag, output logic [127:0] expv);
    expv = '0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'(sb.size()), 128'd1);
    end else begin
      expv = sb.pop_front();
      chk(tag, plain_text, expv);
    end
  endtask

  task automatic out_hs();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("ov_drop", {127'b0, out_valid}, 128'd0);
  endtask

  initial begin
    int lat, bcnt, ovc;
    logic [127:0] expv;

    rst_n = 1'b0; in_valid = 1'b0; in_key_load = 1'b0; out_ready = 1'b0;
    key = '0; cipher_text = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",  {127'b0, in_ready},  128'd0);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_pt",        plain_text,          128'd0);
    chk("rst_busy",      {127'b0, busy},      128'd0);
    chk("rst_key_valid", {127'b0, key_valid}, 128'd0);
    chk("rst_err",       {127'b0, err_nokey}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_in_ready", {127'b0, in_ready}, 128'd1);

    // Request without a key: dropped with a single error pulse
    @(negedge clk);
    in_valid = 1'b1; in_key_load = 1'b0; cipher_text = CB;
    #1;
    chk("nokey_err_hi", {127'b0, err_nokey}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("nokey_err_lo",  {127'b0, err_nokey}, 128'd0);
    chk("nokey_in_rdy",  {127'b0, in_ready},  128'd1);
    ovc = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    chk("nokey_no_out", 128'(ovc), 128'd0);

    // FIPS-197 Appendix B with key load
    start_req(1'b1, KB, CB, PB);
    wait_out(lat, bcnt);
    chk("kl_latency", 128'(lat), 128'd21);
    pop_check("kl_pt_B", expv);
    chk("kl_key_valid", {127'b0, key_valid}, 128'd1);
    out_hs();

    // Key reuse: 11-cycle latency, busy exactly 11 cycles
    @(negedge clk);
    start_req(1'b0, '0, CB, PB);
    wait_out(lat, bcnt);
    chk("reuse_latency", 128'(lat), 128'd11);
    chk("reuse_busy",    128'(bcnt), 128'd11);
    pop_check("reuse_pt_B", expv);
    out_hs();

    // Backpressure in HOLD with a pending request
    start_req(1'b0, '0, CB, PB);
    wait_out(lat, bcnt);
    pop_check("bp_pt_B", expv);
    in_valid = 1'b1; in_key_load = 1'b0; cipher_text = CB;
    sb.push_back(PB);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_pt",  plain_text,             expv);
      chk("hold_rdy", {127'b0, in_ready},     128'd0);
      chk("hold_ov",  {127'b0, out_valid},    128'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("bp_ov_drop", {127'b0, out_valid}, 128'd0);
    chk("bp_in_rdy",  {127'b0, in_ready},  128'd1);
    chk("bp_pt_keep", plain_text,          expv);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_pending_busy", {127'b0, busy}, 128'd1);
    wait_out(lat, bcnt);
    chk("bp_pending_lat", 128'(lat), 128'd11);
    pop_check("bp_pending_pt", expv);
    out_hs();

    // FIPS-197 C.1 with key load, then reuse
    start_req(1'b1, KC, CC, PC);
    wait_out(lat, bcnt);
    chk("c1_latency", 128'(lat), 128'd21);
    pop_check("c1_pt", expv);
    out_hs();
    start_req(1'b0, '0, CC, PC);
    wait_out(lat, bcnt);
    chk("c1_reuse_lat", 128'(lat), 128'd11);
    pop_check("c1_reuse_pt", expv);
    out_hs();

    // Reset at DECRYPT round 5
    start_req(1'b0, '0, CC, PC);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {127'b0, busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",  {127'b0, out_valid}, 128'd0);
    chk("mid_rst_kv",  {127'b0, key_valid}, 128'd0);
    chk("mid_rst_pt",  plain_text,          128'd0);
    chk("mid_rst_busy", {127'b0, busy},     128'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_key_load = 1'b0; cipher_text = CC;
    #1;
    chk("post_rst_err", {127'b0, err_nokey}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ovc = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    chk("post_rst_no_out", 128'(ovc), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_aes_iter_ctrl.md
Name: inv_aes_iter_ctrl

Overview:
- Iterative AES-128 decryption controller that shares one inv_round, one inv_keygen and one inv_add_round_keys instance over time, instead of the ten-round unrolled chain.
- On a new key it expands the key schedule once into an 11-entry round-key store.
- It then sequences the initial add-round-key, inv_rounds 1..9 and the final inv_round (last flag = 1), using keys in reverse order 10..0.
- It sits between the host-side command/response interface and the inverse datapath.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.
- RST_KEY, 128'h0, round-key-0 value loaded into the key store on reset; key_valid stays 0 until a real key load.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  controller can accept a request
- in_key_load  input  1  qualifies key as a new cipher key; sampled with the in_valid/in_ready handshake
- key  input  128  cipher key (round key 0), used only when in_key_load=1
- cipher_text  input  128  block to decrypt
- out_valid  output  1  plain_text valid
- out_ready  input  1  consumer accepts result
- plain_text  output  128  decrypted block, held stable while out_valid=1
- busy  output  1  high in EXPAND or DECRYPT
- key_valid  output  1  key store holds a complete schedule
- err_nokey  output  1  one-cycle pulse when a request is rejected for lack of a key

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE, round counter=0, in_ready=0 during reset then 1 in IDLE, out_valid=0, plain_text=0, busy=0, key_valid=0, err_nokey=0.
- A reset mid-operation aborts everything with no partial output, and the key schedule is invalidated.
- States are IDLE, EXPAND, DECRYPT, HOLD.
- IDLE:
  - in_ready=1.
  - Handshake (in_valid & in_ready) captures cipher_text into the state register.
  - If in_key_load=1: write key into store[0], set key_valid=0, go to EXPAND with rcon index 1.
  - Else if key_valid=1: go to DECRYPT.
  - Else: pulse err_nokey, stay in IDLE, drop the request.
- EXPAND:
  - One inv_keygen step per cycle: store[i] = keygen(i, store[i-1]) for i=1..10.
  - The rcon index is 4 bits and runs 4'h1..4'ha.
  - After writing store[10], set key_valid=1 and go to DECRYPT. This takes 10 cycles.
- DECRYPT, with round counter r=0..10:
  - r=0: state = state XOR store[10].
  - r=1..9: state = inv_round(state, last=0, store[10-r]).
  - r=10: state = inv_round(state, last=1, store[0]), then go to HOLD.
  - This takes 11 cycles.
- HOLD:
  - out_valid=1 and plain_text=state register.
  - On out_ready=1: out_valid drops next cycle, go to IDLE.
  - plain_text keeps its last value after the handshake.
- in_ready=0 in every state except IDLE, so no request is accepted while busy or holding.
- A request held on in_valid while not ready is accepted on the first IDLE cycle; the earliest is the cycle after the out handshake.
- Latency from accept edge to out_valid high:
  - with key load: 21 cycles (10 EXPAND + 11 DECRYPT);
  - with key reuse: 11 cycles.
- Throughput with key reuse and out_ready tied high is one block per 13 cycles (accept, 11 DECRYPT, 1 HOLD).
- in_key_load=1 with key equal to the stored key still re-expands; there is no comparison.
- All round datapath is combinational between the state register and the key store. Only the state, the key store, the counter and the FSM are registered.

Decomposition:
- Package inv_aes_pkg holds:
  - NR=10, NK_WORDS=4, BLOCK_W=128;
  - the FSM state enum (IDLE, EXPAND, DECRYPT, HOLD);
  - the round-counter width (4 bits);
  - the key-store index type (0..10).
- Sub-module inv_aes_key_store:
  - an 11x128 register file with one synchronous write port and one combinational read port;
  - valid flag cleared on write to entry 0 and set on write to entry 10.
- The existing inv_round, inv_keygen and inv_add_round_keys are instantiated once each.

Test Plan:
- Load key 2b7e151628aed2a6abf7158809cf4f3c with cipher_text 3925841d02dc09fbdc118597196a0b32 -> out_valid 21 cycles after accept, plain_text=3243f6a8885a308d313198a2e0370734, key_valid=1.
- Same key, second request without key load, same cipher_text -> identical plain_text after 11 cycles, busy high exactly 11 cycles.
- Request with in_key_load=0 right after reset -> err_nokey single pulse, no out_valid, in_ready stays 1.
- Hold out_ready=0 for 5 cycles in HOLD with in_valid=1 pending -> plain_text stable, in_ready=0; after the out handshake, the pending request is accepted next cycle.
- Assert rst_n=0 at DECRYPT r=5 -> out_valid=0, key_valid=0, plain_text=0 immediately (async); the next request without key load gets err_nokey.
- FIPS-197 C.1 key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_text 00112233445566778899aabbccddeeff.
